// File: rtl/matrix_op_sequencer_if.sv
// Bundle of the sequencer's command, line, arithmetic-unit and result channels.
// Latency: none (signal bundle only).
// Backpressure: valid/ready pairs on the op, line and result channels; au_ready is a plain strobe.
interface matrix_op_sequencer_if;
  logic         op_valid;
  logic [1:0]   op_code;
  logic         op_ready;
  logic         line_valid;
  logic [31:0]  line_data;
  logic         line_ready;
  logic [255:0] matrix_a;
  logic [255:0] matrix_b;
  logic [7:0]   readed_lines_count;
  logic         add;
  logic         sub;
  logic         mult;
  logic         au_reset;
  logic         au_ready;
  logic [255:0] au_result;
  logic         result_valid;
  logic [255:0] result_data;
  logic         result_err;
  logic         result_ready;

  // Sequencer side
  modport master (
    input  op_valid, op_code, line_valid, line_data, au_ready, au_result, result_ready,
    output op_ready, line_ready, matrix_a, matrix_b, readed_lines_count,
           add, sub, mult, au_reset, result_valid, result_data, result_err
  );

  // Environment side (command source, line source, arithmetic unit, result sink)
  modport slave (
    output op_valid, op_code, line_valid, line_data, au_ready, au_result, result_ready,
    input  op_ready, line_ready, matrix_a, matrix_b, readed_lines_count,
           add, sub, mult, au_reset, result_valid, result_data, result_err
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Runs one matrix op: accept a command, load 16 rows into A/B, drive the arithmetic unit, return its result.
// Latency: EXEC starts the cycle after the 16th row; result_valid rises one cycle after au_ready is sampled.
// Backpressure: op_ready only in IDLE, line_ready only in LOAD; the result is held in DONE until result_ready.
module matrix_op_sequencer #(
  parameter int TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   reset,
  matrix_op_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]   state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [255:0] mat_a_q, mat_a_d;
  logic [255:0] mat_b_q, mat_b_d;
  logic [255:0] res_data_q, res_data_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   wait_q, wait_d;
  logic         res_err_q, res_err_d;
  logic         au_reset_q, au_reset_d;
  logic         op_ready_q, line_ready_q, res_valid_q;
  logic         add_q, sub_q, mult_q;

  logic         op_fire, line_fire, res_fire;
  logic [7:0]   row_msb;

  assign op_fire   = bus.op_valid & op_ready_q;
  assign line_fire = bus.line_valid & line_ready_q;
  assign res_fire  = bus.result_ready & res_valid_q;
  // Row k of each operand lands MSB-first: row 0 occupies [255:224]
  assign row_msb   = 8'd255 - {cnt_q[2:0], 5'd0};

  // Next-state, operand loading, wait counter and result capture
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    res_data_d = res_data_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    res_err_d  = res_err_q;
    au_reset_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_fire) begin
          if (bus.op_code == OP_ILL) begin
            // Illegal command never touches the arithmetic unit
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = S_DONE;
          end else begin
            op_d       = bus.op_code;
            mat_a_d    = '0;
            mat_b_d    = '0;
            cnt_d      = '0;
            au_reset_d = 1'b1;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (line_fire) begin
          if (!cnt_q[3]) mat_a_d[row_msb -: 32] = bus.line_data;
          else           mat_b_d[row_msb -: 32] = bus.line_data;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd15) begin
            wait_d  = '0;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        // A result arriving on the timeout cycle still counts as success
        if (bus.au_ready) begin
          res_data_d = bus.au_result;
          res_err_d  = 1'b0;
          state_d    = S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = S_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DONE: begin
        if (res_fire) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; handshake and op-select outputs are registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ADD;
      mat_a_q      <= '0;
      mat_b_q      <= '0;
      res_data_q   <= '0;
      cnt_q        <= '0;
      wait_q       <= '0;
      res_err_q    <= 1'b0;
      au_reset_q   <= 1'b0;
      op_ready_q   <= 1'b0;
      line_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      add_q        <= 1'b0;
      sub_q        <= 1'b0;
      mult_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      mat_a_q      <= mat_a_d;
      mat_b_q      <= mat_b_d;
      res_data_q   <= res_data_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      res_err_q    <= res_err_d;
      au_reset_q   <= au_reset_d;
      op_ready_q   <= (state_d == S_IDLE);
      line_ready_q <= (state_d == S_LOAD);
      res_valid_q  <= (state_d == S_DONE);
      add_q        <= (state_d == S_EXEC) && (op_d == OP_ADD);
      sub_q        <= (state_d == S_EXEC) && (op_d == OP_SUB);
      mult_q       <= (state_d == S_EXEC) && (op_d == OP_MULT);
    end
  end

  assign bus.op_ready           = op_ready_q;
  assign bus.line_ready         = line_ready_q;
  assign bus.matrix_a           = mat_a_q;
  assign bus.matrix_b           = mat_b_q;
  assign bus.readed_lines_count = cnt_q;
  assign bus.add                = add_q;
  assign bus.sub                = sub_q;
  assign bus.mult               = mult_q;
  assign bus.au_reset           = au_reset_q;
  assign bus.result_valid       = res_valid_q;
  assign bus.result_data        = res_data_q;
  assign bus.result_err         = res_err_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Testbench for matrix_op_sequencer: randomized ops against a behavioural reference model.
// Latency: cycle-accurate checks of EXEC entry, EXEC length and result_valid timing.
// Backpressure: random line gaps and held-off result_ready.
module tb_matrix_op_sequencer;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  matrix_op_sequencer_if bus();

  matrix_op_sequencer #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] lines [16];

  // Observations gathered while driving one op
  int           obs_aurst, obs_exec, obs_stall;
  logic [2:0]   obs_sel;
  logic         obs_multi, obs_lr_seen, obs_busy_opr, obs_unstable, obs_rv_first, obs_lat_ok;
  logic         obs_first_exec, obs_clr, obs_err, obs_rv_after, obs_opr_after;
  logic [255:0] obs_a, obs_b, obs_data, obs_data_after;
  logic [7:0]   obs_cnt, obs_cnt_after;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: operand A is rows 0..7 side by side, B is rows 8..15
  function automatic logic [255:0] model_a();
    return {lines[0], lines[1], lines[2], lines[3], lines[4], lines[5], lines[6], lines[7]};
  endfunction
  function automatic logic [255:0] model_b();
    return {lines[8], lines[9], lines[10], lines[11], lines[12], lines[13], lines[14], lines[15]};
  endfunction
  function automatic logic [2:0] model_sel(input logic [1:0] code);
    case (code)
      2'b00:   return 3'b100;
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (bus.au_reset) obs_aurst++;
    if (bus.add || bus.sub || bus.mult) begin
      obs_exec++;
      obs_sel = {bus.add, bus.sub, bus.mult};
      if ($countones({bus.add, bus.sub, bus.mult}) > 1) obs_multi = 1'b1;
    end
    if (bus.line_ready) obs_lr_seen = 1'b1;
    if (bus.op_ready && (bus.line_ready || bus.add || bus.sub || bus.mult || bus.result_valid))
      obs_busy_opr = 1'b1;
  endtask

  task automatic clear_inputs();
    bus.op_valid = 0; bus.op_code = 0; bus.line_valid = 0; bus.line_data = 0;
    bus.au_ready = 0; bus.au_result = 0; bus.result_ready = 0;
  endtask

  // Drives one complete op; au_delay = EXEC cycle index where au_ready pulses (out of range = never)
  task automatic drive_op(input logic [1:0] code, input int gap_pct, input int au_delay,
                          input logic [255:0] au_val, input int rr_hold);
    bit fire;
    int n, i, e;
    logic prev_au;
    obs_aurst = 0; obs_exec = 0; obs_stall = 0; obs_sel = 0; obs_multi = 0; obs_lr_seen = 0;
    obs_busy_opr = 0; obs_unstable = 0; obs_lat_ok = 0; obs_first_exec = 0; obs_clr = 0;
    obs_a = 0; obs_b = 0; obs_cnt = 0;
    bus.op_valid = 1'b1; bus.op_code = code;
    fire = 0; n = 0;
    while (!fire && n < 50) begin
      fire = (bus.op_ready === 1'b1);
      tick(); n++;
    end
    bus.op_valid = 1'b0;
    if (!fire) obs_stall++;
    obs_rv_first = bus.result_valid;
    obs_clr = (bus.matrix_a === '0) && (bus.matrix_b === '0) && (bus.readed_lines_count === 8'd0);
    if (code != 2'b11) begin
      i = 0; n = 0;
      while (i < 16 && n < 600) begin
        bus.line_valid = ($urandom_range(99) >= gap_pct);
        bus.line_data  = bus.line_valid ? lines[i] : $urandom;
        bus.op_valid   = 1'($urandom_range(1));
        bus.op_code    = 2'($urandom_range(3));
        bus.au_ready   = 1'($urandom_range(1));
        bus.au_result  = rand256();
        fire = bus.line_valid && bus.line_ready;
        tick(); n++;
        if (fire) i++;
      end
      bus.line_valid = 0; bus.op_valid = 0; bus.au_ready = 0;
      if (i < 16) obs_stall++;
      obs_first_exec = bus.add || bus.sub || bus.mult;
      obs_a = bus.matrix_a; obs_b = bus.matrix_b; obs_cnt = bus.readed_lines_count;
      e = 0; n = 0; prev_au = 0;
      while (bus.result_valid !== 1'b1 && n < TO + 20) begin
        bus.au_ready  = (e == au_delay);
        bus.au_result = bus.au_ready ? au_val : rand256();
        prev_au = bus.au_ready;
        tick(); e++; n++;
      end
      bus.au_ready = 0;
      obs_lat_ok = prev_au;
      if (bus.result_valid !== 1'b1) obs_stall++;
    end else begin
      n = 0;
      while (bus.result_valid !== 1'b1 && n < 5) begin tick(); n++; end
      if (bus.result_valid !== 1'b1) obs_stall++;
    end
    obs_data = bus.result_data; obs_err = bus.result_err;
    for (int h = 0; h < rr_hold; h++) begin
      bus.result_ready = 0;
      bus.line_valid = 1'($urandom_range(1)); bus.line_data = $urandom;
      bus.au_ready = 1'($urandom_range(1)); bus.au_result = rand256();
      tick();
      if (bus.result_valid !== 1'b1 || bus.result_data !== obs_data ||
          bus.result_err !== obs_err || bus.op_ready !== 1'b0) obs_unstable = 1'b1;
    end
    bus.line_valid = 0; bus.au_ready = 0; bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 0;
    obs_rv_after = bus.result_valid; obs_cnt_after = bus.readed_lines_count;
    obs_data_after = bus.result_data; obs_opr_after = bus.op_ready;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1; #2; reset = 1'b0; #1;
    n_checks++; if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL reset_op_ready: got %b want 0", bus.op_ready); end
    n_checks++; if ({bus.line_ready, bus.add, bus.sub, bus.mult, bus.au_reset, bus.result_valid, bus.result_err} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0", {bus.line_ready, bus.add, bus.sub, bus.mult, bus.au_reset, bus.result_valid, bus.result_err}); end
    n_checks++; if ({bus.matrix_a, bus.matrix_b, bus.result_data} !== '0 || bus.readed_lines_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_data: count got %0d want 0 (matrix/result not all zero)", bus.readed_lines_count); end
    @(posedge clk); @(posedge clk); #2;
    n_checks++; if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL reset_held_op_ready: got %b want 0", bus.op_ready); end
    reset = 1'b1;
    tick();
    n_checks++; if (bus.op_ready !== 1'b1 || bus.line_ready !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: op_ready=%b line_ready=%b result_valid=%b want 1 0 0", bus.op_ready, bus.line_ready, bus.result_valid); end
  endtask

  task automatic test_add();
    logic [255:0] v = rand256();
    for (int k = 0; k < 16; k++) lines[k] = 32'h11111111;
    drive_op(2'b00, 0, 3, v, 0);
    n_checks++; if (obs_stall !== 0) begin n_fail++; $display("FAIL add_stall: got %0d want 0", obs_stall); end
    n_checks++; if (obs_aurst !== 1) begin n_fail++; $display("FAIL add_au_reset_pulses: got %0d want 1", obs_aurst); end
    n_checks++; if (obs_clr !== 1'b1) begin n_fail++; $display("FAIL add_clear_on_accept: got %b want 1", obs_clr); end
    n_checks++; if (obs_first_exec !== 1'b1) begin n_fail++; $display("FAIL add_exec_entry: got %b want 1", obs_first_exec); end
    n_checks++; if (obs_sel !== 3'b100 || obs_multi !== 1'b0) begin n_fail++; $display("FAIL add_select: got %b multi=%b want 100", obs_sel, obs_multi); end
    n_checks++; if (obs_exec !== 4) begin n_fail++; $display("FAIL add_exec_cycles: got %0d want 4", obs_exec); end
    n_checks++; if (obs_lat_ok !== 1'b1) begin n_fail++; $display("FAIL add_result_latency: got %b want 1", obs_lat_ok); end
    n_checks++; if (obs_data !== v || obs_err !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h err=%b want %h err=0", obs_data, obs_err, v); end
    n_checks++; if (obs_a !== {8{32'h11111111}} || obs_b !== {8{32'h11111111}}) begin n_fail++; $display("FAIL add_operands: got a=%h b=%h", obs_a, obs_b); end
  endtask

  task automatic test_line_mapping();
    for (int k = 0; k < 16; k++) lines[k] = 32'(k);
    drive_op(2'b01, 0, 0, rand256(), 0);
    n_checks++; if (obs_a[255:224] !== 32'd0 || obs_a[31:0] !== 32'd7) begin n_fail++; $display("FAIL map_a_ends: got %h %h want 0 7", obs_a[255:224], obs_a[31:0]); end
    n_checks++; if (obs_b[255:224] !== 32'd8 || obs_b[31:0] !== 32'd15) begin n_fail++; $display("FAIL map_b_ends: got %h %h want 8 f", obs_b[255:224], obs_b[31:0]); end
    n_checks++; if (obs_a !== model_a() || obs_b !== model_b()) begin n_fail++; $display("FAIL map_full: got a=%h b=%h", obs_a, obs_b); end
    n_checks++; if (obs_cnt !== 8'd16) begin n_fail++; $display("FAIL map_count: got %0d want 16", obs_cnt); end
    n_checks++; if (obs_sel !== 3'b010 || obs_exec !== 1) begin n_fail++; $display("FAIL map_sub_exec: sel=%b cycles=%0d want 010 1", obs_sel, obs_exec); end
  endtask

  task automatic test_backpressure();
    logic [255:0] v = rand256();
    logic [1:0] code = 2'($urandom_range(2));
    for (int k = 0; k < 16; k++) lines[k] = $urandom;
    drive_op(code, 50, 5, v, 10);
    n_checks++; if (obs_stall !== 0) begin n_fail++; $display("FAIL bp_stall: got %0d want 0", obs_stall); end
    n_checks++; if (obs_a !== model_a() || obs_b !== model_b() || obs_cnt !== 8'd16) begin n_fail++; $display("FAIL bp_lines: count %0d a=%h", obs_cnt, obs_a); end
    n_checks++; if (obs_unstable !== 1'b0 || obs_busy_opr !== 1'b0) begin n_fail++; $display("FAIL bp_hold: unstable=%b op_ready_busy=%b want 0 0", obs_unstable, obs_busy_opr); end
    n_checks++; if (obs_data !== v || obs_sel !== model_sel(code)) begin n_fail++; $display("FAIL bp_result: got %h sel=%b want %h", obs_data, obs_sel, v); end
    n_checks++; if (obs_rv_after !== 1'b0 || obs_cnt_after !== 8'd0 || obs_opr_after !== 1'b1) begin
      n_fail++; $display("FAIL bp_handshake: rv=%b cnt=%0d op_ready=%b want 0 0 1", obs_rv_after, obs_cnt_after, obs_opr_after); end
    n_checks++; if (obs_data_after !== v) begin n_fail++; $display("FAIL bp_retain: got %h want %h", obs_data_after, v); end
  endtask

  task automatic test_illegal();
    drive_op(2'b11, 0, -1, '0, 3);
    n_checks++; if (obs_rv_first !== 1'b1) begin n_fail++; $display("FAIL ill_valid_next: got %b want 1", obs_rv_first); end
    n_checks++; if (obs_err !== 1'b1 || obs_data !== '0) begin n_fail++; $display("FAIL ill_result: err=%b data=%h want 1 0", obs_err, obs_data); end
    n_checks++; if (obs_lr_seen !== 1'b0 || obs_aurst !== 0 || obs_exec !== 0) begin
      n_fail++; $display("FAIL ill_side_effects: line_ready=%b au_reset=%0d exec=%0d want 0 0 0", obs_lr_seen, obs_aurst, obs_exec); end
    n_checks++; if (obs_unstable !== 1'b0) begin n_fail++; $display("FAIL ill_hold: got %b want 0", obs_unstable); end
  endtask

  task automatic test_timeout();
    logic [255:0] v = rand256();
    for (int k = 0; k < 16; k++) lines[k] = $urandom;
    drive_op(2'b10, 0, -1, v, 0);
    n_checks++; if (obs_exec !== TO) begin n_fail++; $display("FAIL to_cycles: got %0d want %0d", obs_exec, TO); end
    n_checks++; if (obs_err !== 1'b1 || obs_data !== '0 || obs_sel !== 3'b001) begin n_fail++; $display("FAIL to_result: err=%b data=%h sel=%b want 1 0 001", obs_err, obs_data, obs_sel); end
    drive_op(2'b10, 0, TO - 1, v, 0);
    n_checks++; if (obs_err !== 1'b0 || obs_data !== v || obs_exec !== TO) begin
      n_fail++; $display("FAIL to_same_cycle: err=%b cycles=%0d data=%h want 0 %0d %h", obs_err, obs_exec, obs_data, TO, v); end
  endtask

  task automatic test_reset_mid_load();
    int n = 0;
    logic [255:0] v = rand256();
    bus.op_valid = 1'b1; bus.op_code = 2'b00;
    while (bus.op_ready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    bus.op_valid = 1'b0;
    bus.line_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin bus.line_data = $urandom | 32'h1; tick(); end
    bus.line_valid = 1'b0;
    n_checks++; if (bus.readed_lines_count !== 8'd5) begin n_fail++; $display("FAIL rml_precount: got %0d want 5", bus.readed_lines_count); end
    #3; reset = 1'b0; #1;
    n_checks++; if (bus.matrix_a !== '0 || bus.readed_lines_count !== 8'd0 || bus.line_ready !== 1'b0 || bus.op_ready !== 1'b0) begin
      n_fail++; $display("FAIL rml_cleared: count=%0d line_ready=%b op_ready=%b want 0 0 0", bus.readed_lines_count, bus.line_ready, bus.op_ready); end
    @(posedge clk); #2; reset = 1'b1;
    tick();
    n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL rml_op_ready: got %b want 1", bus.op_ready); end
    for (int k = 0; k < 16; k++) lines[k] = $urandom;
    drive_op(2'b00, 20, 2, v, 1);
    n_checks++; if (obs_a !== model_a() || obs_b !== model_b() || obs_data !== v || obs_err !== 1'b0) begin
      n_fail++; $display("FAIL rml_followup: data=%h err=%b want %h 0", obs_data, obs_err, v); end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) begin
      logic [1:0] code = 2'($urandom_range(3));
      int dly = $urandom_range(TO + 2);
      logic [255:0] v = rand256();
      bit ok = (dly < TO);
      for (int k = 0; k < 16; k++) lines[k] = $urandom;
      drive_op(code, $urandom_range(60), dly, v, $urandom_range(3));
      if (code == 2'b11) begin
        n_checks++; if (obs_err !== 1'b1 || obs_data !== '0 || obs_exec !== 0) begin
          n_fail++; $display("FAIL b2b_ill_%0d: err=%b exec=%0d want 1 0", t, obs_err, obs_exec); end
      end else begin
        n_checks++; if (obs_err !== !ok || obs_data !== (ok ? v : '0) || obs_exec !== (ok ? dly + 1 : TO)) begin
          n_fail++; $display("FAIL b2b_res_%0d: err=%b exec=%0d want %b %0d", t, obs_err, obs_exec, !ok, ok ? dly + 1 : TO); end
        n_checks++; if (obs_a !== model_a() || obs_b !== model_b() || obs_sel !== model_sel(code) || obs_aurst !== 1) begin
          n_fail++; $display("FAIL b2b_ops_%0d: sel=%b au_reset=%0d want %b 1", t, obs_sel, obs_aurst, model_sel(code)); end
      end
      n_checks++; if (obs_stall !== 0 || obs_rv_after !== 1'b0 || obs_opr_after !== 1'b1) begin
        n_fail++; $display("FAIL b2b_flow_%0d: stall=%0d rv=%b op_ready=%b want 0 0 1", t, obs_stall, obs_rv_after, obs_opr_after); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_line_mapping();
    test_backpressure();
    test_illegal();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_op_sequencer.md
MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum EXEC cycles to wait for au_ready before aborting.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; also used as the name of the block's reset.
REQ-004 Port: op_valid  input  1  command request.
REQ-005 Port: op_code  input  2  command: 00 add, 01 sub, 10 mult, 11 illegal.
REQ-006 Port: op_ready  output  1  command accepted when op_valid and op_ready are both high.
REQ-007 Port: line_valid  input  1  matrix line present.
REQ-008 Port: line_data  input  32  one matrix row of 8 nibbles, MSB nibble is column 0.
REQ-009 Port: line_ready  output  1  line accepted when line_valid and line_ready are both high.
REQ-010 Port: matrix_a / matrix_b  output  256 each  operand registers to the arithmetic unit.
REQ-011 Port: readed_lines_count  output  8  accepted-line count to the arithmetic unit.
REQ-012 Port: add / sub / mult  output  1 each  one-hot operation select to the arithmetic unit.
REQ-013 Port: au_reset  output  1  active-high reset pulse to the arithmetic unit.
REQ-014 Port: au_ready  input  1  arithmetic unit result valid.
REQ-015 Port: au_result  input  256  arithmetic unit output_matrix.
REQ-016 Port: result_valid  output  1  result available.
REQ-017 Port: result_data  output  256  captured result.
REQ-018 Port: result_err  output  1  set with result_valid on illegal opcode or timeout.
REQ-019 Port: result_ready  input  1  result consumed when result_valid and result_ready are both high.

Function
REQ-020 FSM states: IDLE, LOAD, EXEC, DONE, all registered.
REQ-021 IDLE: op_ready=1. On an accepted legal op_code, latch the op, clear matrix_a, matrix_b and readed_lines_count, pulse au_reset for exactly one cycle, then go to LOAD.
REQ-022 IDLE, accepted op_code 11: go to DONE with result_err=1, result_data=0, and no au_reset.
REQ-023 LOAD: line_ready=1 and op_ready=0.
REQ-024 LOAD line storage: line k (count before increment, k=0..7) is written to matrix_a[255-32k -: 32]; k=8..15 is written to matrix_b[255-32(k-8) -: 32].
REQ-025 LOAD count: each accepted line increments readed_lines_count by 1; when the 16th line is accepted, the count reaches 16 and the next state is EXEC.
REQ-026 EXEC: line_ready=0, exactly one of add/sub/mult is high per the latched op, and readed_lines_count is held at 16.
REQ-027 add/sub/mult are 0 in every state other than EXEC.
REQ-028 EXEC, au_ready sampled high: capture au_result into result_data, set result_err=0, go to DONE; au_ready is ignored outside EXEC.
REQ-029 EXEC timeout: an 8-bit wait counter clears on entry; if it reaches TIMEOUT-1 with au_ready low, go to DONE with result_err=1 and result_data=0.
REQ-030 EXEC, au_ready high in the same cycle as the timeout: success takes priority.
REQ-031 DONE: result_valid=1, and result_data and result_err are held stable until the handshake completes.
REQ-032 DONE, on handshake: go to IDLE, clear result_valid, clear readed_lines_count; result_data is retained.
REQ-033 Latency: the first EXEC cycle immediately follows the cycle in which the 16th line is accepted; result_valid rises one cycle after au_ready is sampled.
REQ-034 line_valid in IDLE, EXEC or DONE is not accepted and has no effect; op_valid outside IDLE is not accepted.

Reset
REQ-035 reset low asynchronously forces state IDLE, and sets to 0: op_ready, line_ready, matrix_a, matrix_b, readed_lines_count, add, sub, mult, au_reset, result_valid, result_data, result_err.
REQ-036 Reset asserted mid-LOAD or mid-EXEC discards all partial data; after reset release, op_ready=1 on the first rising edge.

Verification
REQ-037 Add: op_code 00, then 16 lines of 32'h11111111 -> add high in EXEC, au_reset pulses once, model au_ready after 3 cycles -> result_valid with result_data = model au_result, result_err=0.
REQ-038 Line mapping: lines 0..15 = 32'h0000000k (k = line index) -> matrix_a[255:224]=0, matrix_a[31:0]=7, matrix_b[255:224]=8, matrix_b[31:0]=15, readed_lines_count=16.
REQ-039 Gaps and backpressure: line_valid toggled randomly, result_ready held low 10 cycles -> no lines lost, result stable, op_ready low until handshake.
REQ-040 Illegal op: op_code 11 -> result_valid next cycle, result_err=1, result_data=0, line_ready never high.
REQ-041 Timeout: mult, au_ready held low -> exactly TIMEOUT EXEC cycles, then result_err=1; au_ready and timeout in the same cycle -> result_err=0.
REQ-042 Reset mid-LOAD after 5 lines -> all outputs 0 immediately; a following add of 16 lines completes normally.
